// File: rtl/regfile_decoded_clear.sv
// Register file with one-hot write decode, two async read ports,
// write-to-read bypass, optional zero register and a sequenced clear sweep.
module regfile_decoded_clear #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reg_write_i,
  input  logic [ADDR_WIDTH-1:0]      write_register_i,
  input  logic [DATA_WIDTH-1:0]      write_data_i,
  input  logic [ADDR_WIDTH-1:0]      read_register_1_i,
  input  logic [ADDR_WIDTH-1:0]      read_register_2_i,
  output logic [DATA_WIDTH-1:0]      read_data_1_o,
  output logic [DATA_WIDTH-1:0]      read_data_2_o,
  input  logic                       clear_i,
  output logic                       busy_o,
  output logic [2**ADDR_WIDTH-1:0]   select_register_o,
  output logic                       write_drop_o
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam bit ZERO_EN = (ZERO_REG_EN != 0);
  localparam bit BYP_EN  = (BYPASS_EN != 0);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  wr_zero;
  logic                  accept;
  logic                  sel_en;
  logic [ADDR_WIDTH-1:0] sel_idx;
  logic [NUM_REGS-1:0]   sel;

  // Write acceptance and one-hot row select (write row or sweep row)
  always_comb begin
    wr_zero = ZERO_EN && (write_register_i == '0);
    accept  = reg_write_i && (state_q == S_IDLE) && !wr_zero;
    sel_en  = (state_q == S_CLEAR) || accept;
    sel_idx = (state_q == S_CLEAR) ? cnt_q : write_register_i;
    sel     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = sel_en && (sel_idx == ADDR_WIDTH'(i));
    end
  end

  // Next storage: selected row takes write data, or zero while sweeping
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (sel[i]) begin
        regs_d[i] = (state_q == S_CLEAR) ? '0 : write_data_i;
      end
    end
  end

  // Clear sweep sequencer and dropped-write flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = reg_write_i && (state_q == S_CLEAR) && !wr_zero;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (clear_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, counter, drop pulse and storage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Async read ports: zero reg, then same-cycle bypass, then storage
  always_comb begin
    if (ZERO_EN && read_register_1_i == '0) begin
      read_data_1_o = '0;
    end else if (BYP_EN && accept &&
                 read_register_1_i == write_register_i) begin
      read_data_1_o = write_data_i;
    end else begin
      read_data_1_o = regs_q[read_register_1_i];
    end
    if (ZERO_EN && read_register_2_i == '0) begin
      read_data_2_o = '0;
    end else if (BYP_EN && accept &&
                 read_register_2_i == write_register_i) begin
      read_data_2_o = write_data_i;
    end else begin
      read_data_2_o = regs_q[read_register_2_i];
    end
  end

  assign busy_o            = (state_q == S_CLEAR);
  assign select_register_o = sel;
  assign write_drop_o      = drop_q;

endmodule

// File: tb/tb_regfile_decoded_clear.sv
// Scoreboard bench for regfile_decoded_clear.
// Directed stimulus pushes expectations; a negedge monitor checks them.
module tb_regfile_decoded_clear;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        clr;
  logic        busy;
  logic [31:0] sel;
  logic        drop;

  always #5 clk = ~clk;

  regfile_decoded_clear dut (
    .clk               (clk),
    .reset             (reset),
    .reg_write_i       (we),
    .write_register_i  (wa),
    .write_data_i      (wd),
    .read_register_1_i (ra1),
    .read_register_2_i (ra2),
    .read_data_1_o     (rd1),
    .read_data_2_o     (rd2),
    .clear_i           (clr),
    .busy_o            (busy),
    .select_register_o (sel),
    .write_drop_o      (drop)
  );

  localparam int K_RD1  = 0;
  localparam int K_RD2  = 1;
  localparam int K_BUSY = 2;
  localparam int K_SEL  = 3;
  localparam int K_DROP = 4;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   step = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_RD1:   return "read_data_1";
      K_RD2:   return "read_data_2";
      K_BUSY:  return "busy";
      K_SEL:   return "select";
      default: return "write_drop";
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    e.id   = step;
    sb.push_back(e);
  endtask

  task automatic chk_now(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s (immediate): got %h expected %h",
               step, nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    step++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD1:   act = rd1;
        K_RD2:   act = rd2;
        K_BUSY:  act = {31'b0, busy};
        K_SEL:   act = sel;
        default: act = {31'b0, drop};
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL step %0d %s: got %h expected %h",
                 e.id, kname(e.kind), act, e.val);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: sequence did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    reset = 1'b0;
    we = 1'b0; wa = '0; wd = '0;
    ra1 = '0; ra2 = '0; clr = 1'b0;
    #1;
    chk_now("busy", {31'b0, busy}, 32'd0);
    chk_now("select", sel, 32'd0);
    chk_now("write_drop", {31'b0, drop}, 32'd0);

    cyc();
    push(K_BUSY, 0); push(K_SEL, 0); push(K_DROP, 0);
    cyc();
    reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      push(K_RD1, 0); push(K_RD2, 0);
      cyc();
    end

    we = 1'b1; wa = 5'd9; wd = 32'hDEADBEEF; ra1 = 5'd9; ra2 = 5'd8;
    push(K_SEL, 32'h0000_0200); push(K_RD1, 32'hDEADBEEF);
    push(K_RD2, 0);
    cyc();
    we = 1'b0;
    push(K_SEL, 0); push(K_RD1, 32'hDEADBEEF);
    cyc();

    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0;
    push(K_SEL, 0); push(K_RD1, 0);
    cyc();
    we = 1'b0;
    push(K_RD1, 0); push(K_DROP, 0);
    cyc();

    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i);
      cyc();
    end
    we = 1'b0;

    clr = 1'b1; ra1 = 5'd5; ra2 = 5'd31;
    push(K_BUSY, 0); push(K_RD1, 5); push(K_RD2, 31);
    cyc();
    clr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ra2 = 5'(k);
      push(K_BUSY, 1);
      push(K_SEL, 32'h1 << k);
      push(K_RD1, (k <= 5) ? 32'd5 : 32'd0);
      push(K_RD2, 32'(k));
      cyc();
    end
    push(K_BUSY, 0); push(K_SEL, 0);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      push(K_RD1, 0); push(K_RD2, 0);
      cyc();
    end

    we = 1'b1; wa = 5'd3; wd = 32'd3;
    cyc();
    we = 1'b0; clr = 1'b1; ra1 = 5'd3;
    push(K_RD1, 3);
    cyc();
    clr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      we = (k == 2); clr = (k == 2);
      wa = 5'd3; wd = 32'hAAAA5555;
      push(K_BUSY, 1);
      push(K_SEL, 32'h1 << k);
      push(K_DROP, (k == 3) ? 32'd1 : 32'd0);
      push(K_RD1, (k <= 3) ? 32'd3 : 32'd0);
      cyc();
    end
    we = 1'b0; clr = 1'b0;
    push(K_BUSY, 0); push(K_RD1, 0); push(K_DROP, 0);
    cyc();

    we = 1'b1; wa = 5'd20; wd = 32'd20;
    cyc();
    we = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    reset = 1'b0; ra1 = 5'd20;
    #1;
    chk_now("busy", {31'b0, busy}, 32'd0);
    chk_now("select", sel, 32'd0);
    chk_now("read_data_1", rd1, 32'd0);
    push(K_BUSY, 0); push(K_SEL, 0); push(K_RD1, 0);
    cyc();
    reset = 1'b1; clr = 1'b1;
    push(K_BUSY, 0);
    cyc();
    clr = 1'b0;
    for (int k = 0; k < 32; k++) begin
      push(K_BUSY, 1);
      push(K_SEL, 32'h1 << k);
      cyc();
    end
    push(K_BUSY, 0); push(K_SEL, 0);
    cyc();

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
